// File: rtl/alu_flags_pkg.sv
// Shared enums for the v1 core: ALU op codes, PC jump kinds and the flag bundle.
package alu_flags_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_CMP  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SAR  = 4'h9,
    OP_PASS = 4'hA,
    OP_MUL  = 4'hB
  } alu_op_t;

  typedef enum logic [1:0] {
    JMP_ALWAYS = 2'd0,
    JMP_Z      = 2'd1,
    JMP_NZ     = 2'd2,
    JMP_L      = 2'd3
  } jump_t;

  typedef struct packed {
    logic z;
    logic s;
    logic o;
    logic c;
  } flags_t;

  // Ops that complete at their accept edge; MUL and unused codes are excluded.
  function automatic logic is_single_cycle(alu_op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR, OP_SAR, OP_PASS: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_flags_mul.sv
// mul_iter: shift-add unsigned multiplier, one partial product per cycle.
// The last iteration is folded into o_product so o_done marks the finishing edge.
module mul_iter #(
  parameter int D_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [D_WIDTH-1:0]     i_a,
  input  logic [D_WIDTH-1:0]     i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2*D_WIDTH-1:0]   o_product
);

  localparam int CW = (D_WIDTH > 2) ? $clog2(D_WIDTH) : 1;

  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic [2*D_WIDTH-1:0] r_mcand;
  logic [D_WIDTH-1:0]   r_mplier;
  logic [2*D_WIDTH-1:0] r_acc;
  logic [2*D_WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == CW'(D_WIDTH - 1));
  assign o_product  = w_acc_next;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{D_WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_flags.sv
// Execute-stage ALU with Z/S/O/C flag register. Define ALU_MUL_EN to build the
// iterative multi-cycle MUL; otherwise MUL behaves as an undefined op code.
module alu_flags
  import alu_flags_pkg::*;
#(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  alu_op_t            op,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic               flags_we,
  output logic               res_valid,
  output logic [D_WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_s,
  output logic               flag_o,
  output logic               flag_c
);

  localparam int MSB = D_WIDTH - 1;

  logic [D_WIDTH-1:0] r_result;
  logic               r_res_valid;
  flags_t             r_flags;

  logic               w_accept;
  logic               w_single;
  logic [D_WIDTH:0]   w_sum;
  logic [D_WIDTH:0]   w_diff;
  logic [D_WIDTH-1:0] w_res;
  flags_t             w_flags;

  assign w_accept = op_valid && op_ready;
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_res    = '0;
    w_flags  = '0;
    w_single = is_single_cycle(op);
    case (op)
      OP_ADD: begin
        w_res     = w_sum[MSB:0];
        w_flags.c = w_sum[D_WIDTH];
        w_flags.o = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_res     = w_diff[MSB:0];
        w_flags.c = w_diff[D_WIDTH];
        w_flags.o = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_PASS: w_res = b;
      OP_SHL: begin
        w_res     = {a[MSB-1:0], 1'b0};
        w_flags.c = a[MSB];
      end
      OP_SHR: begin
        w_res     = {1'b0, a[MSB:1]};
        w_flags.c = a[0];
      end
      OP_SAR: begin
        w_res     = {a[MSB], a[MSB:1]};
        w_flags.c = a[0];
      end
      default: w_res = '0;
    endcase
    w_flags.z = (w_res == '0);
    w_flags.s = w_res[MSB];
  end

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mul_fwe;
  logic                 w_mul_start;
  logic                 w_mul_busy;
  logic                 w_mul_fin;
  logic                 w_mul_done;
  logic [2*D_WIDTH-1:0] w_prod;
  flags_t               w_mul_flags;

  assign w_mul_start = w_accept && (op == OP_MUL);
  assign w_mul_done  = (r_state == ST_MUL) && w_mul_fin;

  always_comb begin
    w_mul_flags   = '0;
    w_mul_flags.z = (w_prod[MSB:0] == '0);
    w_mul_flags.s = w_prod[MSB];
    w_mul_flags.o = |w_prod[2*D_WIDTH-1:D_WIDTH];
    w_mul_flags.c = |w_prod[2*D_WIDTH-1:D_WIDTH];
  end

  mul_iter #(.D_WIDTH(D_WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_fin),
    .o_product (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    op_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid && (op == OP_MUL)) w_state_next = ST_MUL;
      end
      ST_MUL: begin
        // Leaving on !busy as well keeps the FSM from ever stranding in MUL.
        if (w_mul_done || !w_mul_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end
`else
  assign op_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_flags     <= '0;
`ifdef ALU_MUL_EN
      r_mul_fwe   <= 1'b0;
`endif
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept && w_single) begin
        // CMP is a flags-only op: it never touches result or res_valid.
        if (op != OP_CMP) begin
          r_result    <= w_res;
          r_res_valid <= 1'b1;
        end
        if ((op == OP_CMP) || flags_we) r_flags <= w_flags;
      end
`ifdef ALU_MUL_EN
      if (w_mul_start) r_mul_fwe <= flags_we;
      if (w_mul_done) begin
        r_result    <= w_prod[MSB:0];
        r_res_valid <= 1'b1;
        if (r_mul_fwe) r_flags <= w_mul_flags;
      end
`endif
    end
  end

  assign result    = r_result;
  assign res_valid = r_res_valid;
  assign flag_z    = r_flags.z;
  assign flag_s    = r_flags.s;
  assign flag_o    = r_flags.o;
  assign flag_c    = r_flags.c;

endmodule

// File: tb/tb_alu_flags.sv
// Directed-vector bench for alu_flags (D_WIDTH=8); MUL scenarios follow ALU_MUL_EN.
module tb_alu_flags;
  import alu_flags_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  alu_op_t      op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flags_we;
  logic         res_valid;
  logic [W-1:0] result;
  logic         flag_z, flag_s, flag_o, flag_c;

  int n_checks = 0;
  int n_fail   = 0;

  alu_flags #(.D_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flags_we  (flags_we),
    .res_valid (res_valid),
    .result    (result),
    .flag_z    (flag_z),
    .flag_s    (flag_s),
    .flag_o    (flag_o),
    .flag_c    (flag_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] zsoc();
    return {flag_z, flag_s, flag_o, flag_c};
  endfunction

  task automatic drive(input alu_op_t o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic fwe);
    op_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    flags_we = fwe;
  endtask

  // Issue one op (left valid, so consecutive calls are back-to-back) and check it.
  task automatic run_vec(input string tag, input alu_op_t o, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic fwe,
                         input logic [W-1:0] exp_res, input logic exp_rv,
                         input logic [3:0] exp_zsoc);
    drive(o, va, vb, fwe);
    step();
    check({tag, ".result"}, result, exp_res);
    check({tag, ".res_valid"}, res_valid, exp_rv);
    check({tag, ".zsoc"}, zsoc(), exp_zsoc);
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op       = OP_ADD;
    a        = '0;
    b        = '0;
    flags_we = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset.op_ready", op_ready, 1'b1);
    check("reset.res_valid", res_valid, 1'b0);
    check("reset.result", result, 8'h00);
    check("reset.zsoc", zsoc(), 4'b0000);

    run_vec("add_ovf", OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1, 4'b0110);
    op_valid = 1'b0;
    step();
    check("idle.res_valid", res_valid, 1'b0);
    check("idle.result_held", result, 8'h80);

    run_vec("sub_borrow", OP_SUB, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 4'b0101);
    run_vec("sar", OP_SAR, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 4'b0101);
    run_vec("cmp_eq", OP_CMP, 8'h05, 8'h05, 1'b0, 8'hC0, 1'b0, 4'b1000);
    run_vec("add_nofl", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 4'b1000);

    drive(alu_op_t'(4'hF), 8'h00, 8'h00, 1'b1);
    step();
    check("undef.op_ready", op_ready, 1'b1);
    check("undef.res_valid", res_valid, 1'b0);
    check("undef.result", result, 8'h02);
    check("undef.zsoc", zsoc(), 4'b1000);

    run_vec("xor", OP_XOR, 8'hF0, 8'hFF, 1'b1, 8'h0F, 1'b1, 4'b0000);
    run_vec("shl", OP_SHL, 8'h80, 8'h00, 1'b1, 8'h00, 1'b1, 4'b1001);
    run_vec("sub_ovf", OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 4'b0010);
    run_vec("and", OP_AND, 8'hCC, 8'hAA, 1'b1, 8'h88, 1'b1, 4'b0100);
    run_vec("or", OP_OR, 8'h0C, 8'h30, 1'b1, 8'h3C, 1'b1, 4'b0000);
    run_vec("not", OP_NOT, 8'h00, 8'h55, 1'b1, 8'hFF, 1'b1, 4'b0100);
    run_vec("pass", OP_PASS, 8'hAA, 8'h00, 1'b1, 8'h00, 1'b1, 4'b1000);
    run_vec("shr", OP_SHR, 8'h03, 8'h00, 1'b1, 8'h01, 1'b1, 4'b0001);
    run_vec("add_carry", OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 4'b1001);
    run_vec("add_pre", OP_ADD, 8'h20, 8'h05, 1'b1, 8'h25, 1'b1, 4'b0000);

`ifdef ALU_MUL_EN
    drive(OP_MUL, 8'h10, 8'h11, 1'b1);
    step();
    drive(OP_ADD, 8'h03, 8'h04, 1'b1);
    for (int i = 0; i < W; i++) begin
      check($sformatf("mul.busy_ready[%0d]", i), op_ready, 1'b0);
      check($sformatf("mul.busy_rv[%0d]", i), res_valid, 1'b0);
      check($sformatf("mul.busy_result[%0d]", i), result, 8'h25);
      step();
    end
    check("mul.op_ready", op_ready, 1'b1);
    check("mul.result", result, 8'h10);
    check("mul.res_valid", res_valid, 1'b1);
    check("mul.zsoc", zsoc(), 4'b0011);
    step();
    check("mul.held_add.result", result, 8'h07);
    check("mul.held_add.res_valid", res_valid, 1'b1);
    check("mul.held_add.zsoc", zsoc(), 4'b0000);

    drive(OP_MUL, 8'h10, 8'h11, 1'b1);
    step();
    op_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mulrst.op_ready", op_ready, 1'b1);
    check("mulrst.res_valid", res_valid, 1'b0);
    check("mulrst.result", result, 8'h00);
    check("mulrst.zsoc", zsoc(), 4'b0000);
    begin
      int pulses = 0;
      for (int i = 0; i < 2 * W; i++) begin
        step();
        if (res_valid === 1'b1) pulses++;
      end
      check("mulrst.no_pulse", pulses, 0);
    end
    run_vec("post_rst_add", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 4'b0000);
`else
    drive(OP_MUL, 8'h03, 8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("nomul.op_ready[%0d]", i), op_ready, 1'b1);
      check($sformatf("nomul.res_valid[%0d]", i), res_valid, 1'b0);
      check($sformatf("nomul.result[%0d]", i), result, 8'h25);
      check($sformatf("nomul.zsoc[%0d]", i), zsoc(), 4'b0000);
    end
    run_vec("post_mul_add", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 4'b0000);
`endif

    drive(OP_ADD, 8'h40, 8'h40, 1'b1);
    rst = 1'b1;
    step();
    check("rst_prio.result", result, 8'h00);
    check("rst_prio.res_valid", res_valid, 1'b0);
    check("rst_prio.zsoc", zsoc(), 4'b0000);
    rst      = 1'b0;
    op_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flags.md
# alu_flags

Execute-stage ALU with an architectural flag register for the v1 core. It accepts one operation per cycle over a valid/ready handshake and returns a registered result. It also maintains the Z/S/O/C flags that drive the program counter's conditional jumps (JZ/JNZ/JL). An optional iterative multiplier makes MUL a multi-cycle operation that stalls issue.

## Interface
Parameters:
- D_WIDTH, 8, operand/result width (≥ 2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation offered this cycle
- op_ready  out  1  block can accept an operation this cycle
- op  in  alu_op_t  operation code
- a  in  D_WIDTH  operand A
- b  in  D_WIDTH  operand B
- flags_we  in  1  update flags with this operation's result
- res_valid  out  1  one-cycle pulse: result holds a new value
- result  out  D_WIDTH  registered result, held between pulses
- flag_z  out  1  zero
- flag_s  out  1  sign (result MSB)
- flag_o  out  1  signed overflow
- flag_c  out  1  carry / borrow / shifted-out bit

## Operation
- Accept occurs when op_valid && op_ready at a rising edge. op, a, b and flags_we are sampled only at accept.
- Ops and results (r), all computed modulo 2^D_WIDTH:
  - ADD: r = a+b, c = carry out, o = (a.msb==b.msb) && (r.msb!=a.msb)
  - SUB and CMP: r = a−b, c = borrow (a<b unsigned), o = (a.msb!=b.msb) && (r.msb!=a.msb)
  - AND, OR, XOR: bitwise; NOT: r = ~a; PASS: r = b. For all of these, c = o = 0.
  - SHL, SHR, SAR: shift a by one bit; c = the bit shifted out, o = 0.
  - MUL: r = low half of unsigned a*b; c = o = (high half != 0).
- For every op, z = (r==0) and s = r.msb.
- Flags are written only when flags_we was 1 at accept. Exception: CMP always writes flags, never updates result, and never pulses res_valid.
- Any undefined op code: no result, no flag write, op_ready stays 1.
- State machine:
  - IDLE (op_ready=1): a single-cycle op is executed at the accept edge. A MUL accept goes to MUL.
  - MUL (op_ready=0): one shift-add iteration per cycle for D_WIDTH cycles. Then return to IDLE, writing result/res_valid (and flags if captured flags_we) at the same edge.
  - op_valid while in MUL is ignored and not accepted. The upstream stage must hold the op until op_ready.

## Timing
- Reset state: state=IDLE, op_ready=1, res_valid=0, result=0, all flags 0.
- Single-cycle ops: accept at edge E0. result, flags and res_valid=1 are visible after E0. res_valid drops after E1 unless another non-CMP op is accepted at E1. Back-to-back issue gives one result per cycle.
- MUL: accept at E0. op_ready=0 after E0 through E(D_WIDTH−1). At E(D_WIDTH), result, flags and res_valid=1 are written and op_ready=1. A new op may be accepted at E(D_WIDTH+1).
- Flags change only at the edge where the corresponding result is written. The PC samples the updated flags from the following cycle.
- Reset asserted mid-MUL: the multiply is aborted at that edge, no res_valid pulse, all outputs return to reset values.
- Reset has priority over an accept at the same edge.

## Configuration
- ALU_MUL_EN defined: MUL is implemented as described above.
- ALU_MUL_EN undefined:
  - MUL is treated as an undefined op: no result, no flag write, op_ready never deasserts.
  - The MUL state and the multiplier are not compiled.

## Structure
- alu_op_t (explicit 4-bit encodings for ADD, SUB, CMP, AND, OR, XOR, NOT, SHL, SHR, SAR, PASS, MUL) lives in the shared enums header, next to jump_t.
- FSM state typedef is local to the module.
- Sub-module mul_iter: start/busy/done shift-add unsigned multiplier producing a 2·D_WIDTH product. It is instantiated only under ALU_MUL_EN.

## Test plan
All scenarios use D_WIDTH=8.
- ADD 0x7F+0x01, flags_we=1 → after the next edge: result=0x80, res_valid=1, z=0, s=1, o=1, c=0.
- SUB 0x00−0x01, flags_we=1 → result=0xFF, c=1, s=1, o=0, z=0. Then SAR 0x81 → result=0xC0, c=1.
- CMP 0x05,0x05 with flags_we=0 → z=1, c=0. res_valid stays 0 and result is unchanged. Follow with ADD 1+1, flags_we=0 → result=0x02, flags unchanged (z still 1).
- MUL 0x10×0x11, flags_we=1 (ALU_MUL_EN) → op_ready=0 for exactly 8 cycles. An ADD presented during that time is not accepted. Then result=0x10, c=o=1, single res_valid pulse, and the held ADD is accepted next.
- Reset asserted 3 cycles into a MUL → next cycle op_ready=1, res_valid=0, result=0x00, all flags 0, and no pulse later.
- Without ALU_MUL_EN: MUL 3×3 → op_ready stays 1, no res_valid, flags unchanged.
